lsu_sequencer: RTL and testbench

LSU_SEQUENCER -- requirements
Module: lsu_sequencer

---
 rtl/lsu_sequencer.sv | 169 ++++++++++++++++
 tb/tb_lsu_sequencer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/lsu_sequencer.sv
// Load/store sequencer for the MEM stage. It holds at most one outstanding bus
// access and stalls the pipeline until that access completes or times out.
module lsu_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  rd_ctrl,
  input  logic [2:0]  wr_ctrl,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rdata,
  output logic        lsu_stall,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        misaligned,
  output logic        bus_err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  type_q, type_d;
  logic        we_q, we_d;
  logic [31:0] load_data_q, load_data_d;
  logic        bus_err_q, bus_err_d;

  logic        ld_ok, st_ok, start, mis;
  logic [2:0]  sel_ctrl;
  logic [31:0] shifted, extracted;

  // Decode the incoming MEM-stage request; a load takes priority over a store.
  always_comb begin
    ld_ok    = (rd_ctrl != 3'd3) && (rd_ctrl != 3'd6) && (rd_ctrl != 3'd7);
    st_ok    = (wr_ctrl <= 3'd2);
    start    = ld_ok || st_ok;
    sel_ctrl = ld_ok ? rd_ctrl : wr_ctrl;
    mis      = ((sel_ctrl[1:0] == 2'd1) && addr[0]) ||
               ((sel_ctrl[1:0] == 2'd2) && (addr[1:0] != 2'b00));
  end

  // Extract the addressed byte/half from the returned word and extend it.
  always_comb begin
    shifted = mem_rdata >> {addr_q[1:0], 3'b000};
    case (type_q)
      3'd0:    extracted = {{24{shifted[7]}}, shifted[7:0]};
      3'd1:    extracted = {{16{shifted[15]}}, shifted[15:0]};
      3'd4:    extracted = {24'd0, shifted[7:0]};
      3'd5:    extracted = {16'd0, shifted[15:0]};
      default: extracted = mem_rdata;
    endcase
  end

  // Next-state logic: access sequencing, wait-counter timeout and load capture.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    type_d      = type_q;
    we_d        = we_q;
    load_data_d = load_data_q;
    bus_err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && !mis) begin
          addr_d  = addr;
          wdata_d = wdata;
          type_d  = sel_ctrl;
          we_d    = !ld_ok;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (mem_req_ready) begin
          if (mem_rsp_valid) begin
            state_d = S_DONE;
            if (!we_q) load_data_d = extracted;
          end else begin
            state_d = S_WAIT;
            cnt_d   = 8'd0;
          end
        end
      end
      S_WAIT: begin
        if (mem_rsp_valid) begin
          state_d = S_DONE;
          if (!we_q) load_data_d = extracted;
        end else if (cnt_q == 8'd255) begin
          state_d   = S_IDLE;
          bus_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;  // DONE: inputs ignored, same instruction still in MEM
    endcase
  end

  // State registers with asynchronous clear; reset abandons any access silently.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 8'd0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      type_q      <= 3'd0;
      we_q        <= 1'b0;
      load_data_q <= 32'd0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      type_q      <= type_d;
      we_q        <= we_d;
      load_data_q <= load_data_d;
      bus_err_q   <= bus_err_d;
    end
  end

  // Bus request fields come from the latched access so they hold until the handshake.
  always_comb begin
    mem_req_valid = (state_q == S_REQ);
    mem_we        = mem_req_valid && we_q;
    mem_addr      = mem_req_valid ? {addr_q[31:2], 2'b00} : 32'd0;
    mem_wdata     = 32'd0;
    mem_wstrb     = 4'd0;
    if (mem_req_valid && we_q) begin
      case (type_q[1:0])
        2'd0: begin
          mem_wdata = {4{wdata_q[7:0]}};
          mem_wstrb = 4'b0001 << addr_q[1:0];
        end
        2'd1: begin
          mem_wdata = {2{wdata_q[15:0]}};
          mem_wstrb = 4'b0011 << addr_q[1:0];
        end
        default: begin
          mem_wdata = wdata_q;
          mem_wstrb = 4'b1111;
        end
      endcase
    end
  end

  // Stall starts combinationally in the detect cycle so the instruction stays in MEM.
  always_comb begin
    lsu_stall  = (!rst && (state_q == S_IDLE) && start && !mis) ||
                 (state_q == S_REQ) || (state_q == S_WAIT);
    misaligned = !rst && (state_q == S_IDLE) && start && mis;
    load_valid = (state_q == S_DONE) && !we_q;
    load_data  = load_data_q;
    bus_err    = bus_err_q;
  end

endmodule

// File: tb/tb_lsu_sequencer.sv
// Directed self-checking bench for lsu_sequencer.
module tb_lsu_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  rd_ctrl, wr_ctrl;
  logic [31:0] addr, wdata;
  logic        mem_req_valid, mem_req_ready, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_rsp_valid;
  logic [31:0] mem_rdata;
  logic        lsu_stall;
  logic [31:0] load_data;
  logic        load_valid, misaligned, bus_err;

  int passed = 0;
  int total  = 0;

  lsu_sequencer dut (
    .clk(clk), .rst(rst), .rd_ctrl(rd_ctrl), .wr_ctrl(wr_ctrl),
    .addr(addr), .wdata(wdata), .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rsp_valid(mem_rsp_valid),
    .mem_rdata(mem_rdata), .lsu_stall(lsu_stall), .load_data(load_data),
    .load_valid(load_valid), .misaligned(misaligned), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; rd_ctrl = 3'd2; wr_ctrl = 3'd3; addr = 32'h100; wdata = 0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = 0;
    repeat (2) sample();
    total++; if ({mem_req_valid, mem_we, mem_wstrb, lsu_stall, load_valid, misaligned, bus_err} !== 10'd0)
      $display("FAIL reset_ctrl got=%b exp=0", {mem_req_valid, mem_we, mem_wstrb, lsu_stall, load_valid, misaligned, bus_err}); else passed++;
    total++; if ({mem_addr, mem_wdata, load_data} !== 96'd0)
      $display("FAIL reset_data got=%h exp=0", {mem_addr, mem_wdata, load_data}); else passed++;
    rd_ctrl = 3'd3;
    rst = 1'b0;
  endtask

  task automatic test_lw();
    tick(); rd_ctrl = 3'd2; addr = 32'h100; mem_req_ready = 1'b1;
    sample();
    total++; if (lsu_stall !== 1'b1 || mem_req_valid !== 1'b0)
      $display("FAIL lw_detect stall=%b req=%b exp=1/0", lsu_stall, mem_req_valid); else passed++;
    tick(); rd_ctrl = 3'd3;
    sample();
    total++; if (mem_req_valid !== 1'b1 || mem_addr !== 32'h100 || mem_we !== 1'b0 || mem_wstrb !== 4'd0 || lsu_stall !== 1'b1)
      $display("FAIL lw_req req=%b addr=%h we=%b strb=%b stall=%b exp=1/100/0/0000/1", mem_req_valid, mem_addr, mem_we, mem_wstrb, lsu_stall); else passed++;
    tick(); mem_rsp_valid = 1'b1; mem_rdata = 32'hDEADBEEF;
    sample();
    total++; if (lsu_stall !== 1'b1 || mem_req_valid !== 1'b0 || load_valid !== 1'b0)
      $display("FAIL lw_wait stall=%b req=%b lv=%b exp=1/0/0", lsu_stall, mem_req_valid, load_valid); else passed++;
    // a new load presented during DONE must be ignored
    tick(); mem_rsp_valid = 1'b0; mem_rdata = 0; rd_ctrl = 3'd2; addr = 32'h104;
    sample();
    total++; if (load_valid !== 1'b1 || load_data !== 32'hDEADBEEF || lsu_stall !== 1'b0)
      $display("FAIL lw_done lv=%b data=%h stall=%b exp=1/deadbeef/0", load_valid, load_data, lsu_stall); else passed++;
    tick(); rd_ctrl = 3'd3;
    sample();
    total++; if (load_valid !== 1'b0 || lsu_stall !== 1'b0 || mem_req_valid !== 1'b0)
      $display("FAIL lw_after lv=%b stall=%b req=%b exp=0/0/0", load_valid, lsu_stall, mem_req_valid); else passed++;
  endtask

  task automatic test_load_ext(input logic [2:0] ctrl, input logic [31:0] a,
                               input logic [31:0] rd, input logic [31:0] exp);
    tick(); rd_ctrl = ctrl; addr = a; mem_req_ready = 1'b1;
    tick(); rd_ctrl = 3'd3; mem_rsp_valid = 1'b1; mem_rdata = rd;
    sample();
    total++; if (mem_req_valid !== 1'b1 || lsu_stall !== 1'b1)
      $display("FAIL ext_req ctrl=%0d req=%b stall=%b exp=1/1", ctrl, mem_req_valid, lsu_stall); else passed++;
    tick(); mem_rsp_valid = 1'b0; mem_rdata = 0;
    sample();
    total++; if (load_valid !== 1'b1 || load_data !== exp || lsu_stall !== 1'b0)
      $display("FAIL ext_data ctrl=%0d lv=%b got=%h exp=%h", ctrl, load_valid, load_data, exp); else passed++;
  endtask

  task automatic test_store(input logic [2:0] ctrl, input logic [31:0] a, input logic [31:0] wd,
                            input logic [31:0] exp_wd, input logic [3:0] exp_strb);
    tick(); wr_ctrl = ctrl; addr = a; wdata = wd; mem_req_ready = 1'b1;
    tick(); wr_ctrl = 3'd3; wdata = 0; mem_rsp_valid = 1'b1;
    sample();
    total++; if (mem_we !== 1'b1 || mem_wstrb !== exp_strb || mem_wdata !== exp_wd || mem_addr !== {a[31:2], 2'b00})
      $display("FAIL st_req ctrl=%0d we=%b strb=%b wd=%h addr=%h exp strb=%b wd=%h", ctrl, mem_we, mem_wstrb, mem_wdata, mem_addr, exp_strb, exp_wd); else passed++;
    tick(); mem_rsp_valid = 1'b0;
    sample();
    total++; if (load_valid !== 1'b0 || lsu_stall !== 1'b0)
      $display("FAIL st_done ctrl=%0d lv=%b stall=%b exp=0/0", ctrl, load_valid, lsu_stall); else passed++;
  endtask

  task automatic test_load_wins();
    tick(); rd_ctrl = 3'd2; wr_ctrl = 3'd2; addr = 32'h40; wdata = 32'hFFFF_FFFF; mem_req_ready = 1'b1;
    tick(); rd_ctrl = 3'd3; wr_ctrl = 3'd3; mem_rsp_valid = 1'b1; mem_rdata = 32'h5;
    sample();
    total++; if (mem_we !== 1'b0 || mem_wstrb !== 4'd0 || mem_addr !== 32'h40)
      $display("FAIL prio_req we=%b strb=%b addr=%h exp=0/0000/40", mem_we, mem_wstrb, mem_addr); else passed++;
    tick(); mem_rsp_valid = 1'b0;
    sample();
    total++; if (load_valid !== 1'b1 || load_data !== 32'h5)
      $display("FAIL prio_done lv=%b data=%h exp=1/5", load_valid, load_data); else passed++;
  endtask

  task automatic test_misaligned();
    tick(); rd_ctrl = 3'd2; addr = 32'h101;
    sample();
    total++; if (misaligned !== 1'b1 || mem_req_valid !== 1'b0 || lsu_stall !== 1'b0)
      $display("FAIL mis_lw mis=%b req=%b stall=%b exp=1/0/0", misaligned, mem_req_valid, lsu_stall); else passed++;
    tick(); rd_ctrl = 3'd3; wr_ctrl = 3'd1; addr = 32'h103;
    sample();
    total++; if (misaligned !== 1'b1 || mem_req_valid !== 1'b0 || lsu_stall !== 1'b0)
      $display("FAIL mis_sh mis=%b req=%b stall=%b exp=1/0/0", misaligned, mem_req_valid, lsu_stall); else passed++;
    tick(); wr_ctrl = 3'd3;
    sample();
    total++; if (misaligned !== 1'b0 || mem_req_valid !== 1'b0)
      $display("FAIL mis_after mis=%b req=%b exp=0/0", misaligned, mem_req_valid); else passed++;
  endtask

  task automatic test_timeout();
    int bad;
    tick(); wr_ctrl = 3'd2; addr = 32'h200; wdata = 32'h11223344; mem_req_ready = 1'b0;
    tick(); wr_ctrl = 3'd3; wdata = 0; mem_rsp_valid = 1'b1;  // response before handshake is ignored
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) tick();
      sample();
      if (mem_req_valid !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h200 ||
          mem_wdata !== 32'h11223344 || mem_wstrb !== 4'hF || lsu_stall !== 1'b1) bad++;
    end
    total++; if (bad !== 0) $display("FAIL stall_hold bad_cycles=%0d exp=0", bad); else passed++;
    tick(); mem_req_ready = 1'b1; mem_rsp_valid = 1'b0;
    tick(); mem_req_ready = 1'b0;
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      sample();
      if (lsu_stall !== 1'b1 || bus_err !== 1'b0 || mem_req_valid !== 1'b0) bad++;
      tick();
    end
    total++; if (bad !== 0) $display("FAIL wait_window bad_cycles=%0d exp=0", bad); else passed++;
    mem_rsp_valid = 1'b1;  // late response, must be ignored in IDLE
    sample();
    total++; if (bus_err !== 1'b1 || lsu_stall !== 1'b0 || load_valid !== 1'b0)
      $display("FAIL timeout err=%b stall=%b lv=%b exp=1/0/0", bus_err, lsu_stall, load_valid); else passed++;
    tick(); mem_rsp_valid = 1'b0;
    sample();
    total++; if (bus_err !== 1'b0 || load_valid !== 1'b0 || mem_req_valid !== 1'b0)
      $display("FAIL timeout_after err=%b lv=%b req=%b exp=0/0/0", bus_err, load_valid, mem_req_valid); else passed++;
  endtask

  task automatic test_reset_mid();
    tick(); rd_ctrl = 3'd2; addr = 32'h300; mem_req_ready = 1'b1;
    tick(); rd_ctrl = 3'd3;
    tick(); mem_req_ready = 1'b0;  // now in WAIT
    sample();
    total++; if (lsu_stall !== 1'b1)
      $display("FAIL rstmid_wait stall=%b exp=1", lsu_stall); else passed++;
    #2 rst = 1'b1;
    #1;
    total++; if ({mem_req_valid, lsu_stall, load_valid, bus_err, misaligned} !== 5'd0 || load_data !== 32'd0)
      $display("FAIL rstmid_async ctrl=%b data=%h exp=0/0", {mem_req_valid, lsu_stall, load_valid, bus_err, misaligned}, load_data); else passed++;
    sample(); rst = 1'b0;
    tick(); mem_rsp_valid = 1'b1; mem_rdata = 32'hCAFE_F00D;
    sample();
    total++; if (load_valid !== 1'b0 || lsu_stall !== 1'b0)
      $display("FAIL rstmid_rsp lv=%b stall=%b exp=0/0", load_valid, lsu_stall); else passed++;
    tick(); mem_rsp_valid = 1'b0;
    sample();
    total++; if (load_valid !== 1'b0 || load_data !== 32'd0)
      $display("FAIL rstmid_after lv=%b data=%h exp=0/0", load_valid, load_data); else passed++;
  endtask

  initial begin
    test_reset();
    test_lw();
    test_load_ext(3'd0, 32'h103, 32'h80FF_FFFF, 32'hFFFF_FF80);
    test_load_ext(3'd4, 32'h103, 32'h80FF_FFFF, 32'h0000_0080);
    test_load_ext(3'd1, 32'h102, 32'h8001_1234, 32'hFFFF_8001);
    test_load_ext(3'd5, 32'h100, 32'h1234_8765, 32'h0000_8765);
    test_store(3'd1, 32'h102, 32'h1234_ABCD, 32'hABCD_ABCD, 4'b1100);
    test_store(3'd0, 32'h101, 32'h0000_00EF, 32'hEFEF_EFEF, 4'b0010);
    test_store(3'd2, 32'h104, 32'h0BAD_F00D, 32'h0BAD_F00D, 4'b1111);
    test_load_wins();
    test_misaligned();
    test_timeout();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule
